branch_redirect_ctrl: RTL and testbench

Control-transfer redirect and squash controller for the RV32I pipeline. It sits between the execute stage and the fetch/ICACHE front end. It detects taken JAL/JALR/branches in EX and computes the target and link value. It drives a held redirect to fetch, then asserts squash for a fixed number of advancing pipeline cycles, honouring the shared pipeline hold `en`.

---
 rtl/branch_redirect_ctrl.sv | 161 ++++++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_redirect_ctrl
// Description : Detects taken JAL/JALR/branches in EX and computes the target
//               and link value. Drives a held redirect to fetch, then squashes
//               IF/ID for FLUSH_DEPTH advancing cycles, honouring the pipeline
//               hold 'en'.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_redirect_ctrl #(
   parameter int XLEN        = 32,
   parameter int FLUSH_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            ex_valid,
   input  logic            ex_is_jal,
   input  logic            ex_is_jalr,
   input  logic            ex_is_branch,
   input  logic            ex_taken,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_imm,
   input  logic [XLEN-1:0] ex_rs1,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc,
   output logic            squash,
   output logic            link_wr,
   output logic [XLEN-1:0] link_data,
   output logic            misalign
);

   localparam int c_cnt_w = $clog2(FLUSH_DEPTH + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(FLUSH_DEPTH);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
   localparam logic [XLEN-1:0]    c_bit0_clr = {{(XLEN-1){1'b1}}, 1'b0};
   localparam logic [XLEN-1:0]    c_four     = XLEN'(4);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_REDIRECT = 2'd1,
      S_SQUASH   = 2'd2
   } state_t;

   state_t              r_state, w_state_nx;
   logic [c_cnt_w-1:0]  r_cnt, w_cnt_nx;
   logic                r_link_q, w_link_q_nx;
   logic                r_redirect, w_redirect_nx;
   logic                r_squash, w_squash_nx;
   logic                r_link_wr, w_link_wr_nx;
   logic                r_misalign, w_misalign_nx;
   logic [XLEN-1:0]     r_redirect_pc, w_redirect_pc_nx;
   logic [XLEN-1:0]     r_link_data, w_link_data_nx;

   logic                w_event;
   logic                w_is_jump;
   logic [XLEN-1:0]     w_target;
   logic [XLEN-1:0]     w_link;

   // Target/link arithmetic wraps mod 2^XLEN; JALR target has bit 0 cleared
   assign w_is_jump = ex_is_jal | ex_is_jalr;
   assign w_event   = ex_valid & (w_is_jump | (ex_is_branch & ex_taken));
   assign w_target  = ex_is_jalr ? ((ex_rs1 + ex_imm) & c_bit0_clr) : (ex_pc + ex_imm);
   assign w_link    = ex_pc + c_four;

   // Next-state and next-output decode; outputs are registered from these
   always_comb begin
      w_state_nx       = r_state;
      w_cnt_nx         = r_cnt;
      w_link_q_nx      = r_link_q;
      w_redirect_nx    = 1'b0;
      w_squash_nx      = 1'b0;
      w_link_wr_nx     = 1'b0;
      w_misalign_nx    = 1'b0;
      w_redirect_pc_nx = r_redirect_pc;
      w_link_data_nx   = r_link_data;
      case (r_state)
         S_IDLE: begin
            if (!en && w_event) begin
               if (w_target[1]) begin
                  // Misaligned target: flag only, no control transfer
                  w_misalign_nx = 1'b1;
               end else begin
                  w_state_nx       = S_REDIRECT;
                  w_cnt_nx         = c_cnt_load;
                  w_link_q_nx      = w_is_jump;
                  w_redirect_nx    = 1'b1;
                  w_squash_nx      = 1'b1;
                  w_link_wr_nx     = w_is_jump;
                  w_redirect_pc_nx = w_target;
                  w_link_data_nx   = w_link;
               end
            end
         end
         S_REDIRECT: begin
            if (en) begin
               w_redirect_nx = 1'b1;
               w_squash_nx   = 1'b1;
               w_link_wr_nx  = r_link_q;
            end else if (r_cnt == c_cnt_one) begin
               w_state_nx = S_IDLE;
               w_cnt_nx   = '0;
            end else begin
               w_state_nx  = S_SQUASH;
               w_cnt_nx    = r_cnt - c_cnt_one;
               w_squash_nx = 1'b1;
            end
         end
         S_SQUASH: begin
            w_squash_nx = 1'b1;
            if (!en) begin
               if (r_cnt == c_cnt_one) begin
                  w_state_nx  = S_IDLE;
                  w_cnt_nx    = '0;
                  w_squash_nx = 1'b0;
               end else begin
                  w_cnt_nx = r_cnt - c_cnt_one;
               end
            end
         end
         default: begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
         end
      endcase
   end

   // State, counter and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_link_q      <= 1'b0;
         r_redirect    <= 1'b0;
         r_squash      <= 1'b0;
         r_link_wr     <= 1'b0;
         r_misalign    <= 1'b0;
         r_redirect_pc <= '0;
         r_link_data   <= '0;
      end else begin
         r_state       <= w_state_nx;
         r_cnt         <= w_cnt_nx;
         r_link_q      <= w_link_q_nx;
         r_redirect    <= w_redirect_nx;
         r_squash      <= w_squash_nx;
         r_link_wr     <= w_link_wr_nx;
         r_misalign    <= w_misalign_nx;
         r_redirect_pc <= w_redirect_pc_nx;
         r_link_data   <= w_link_data_nx;
      end
   end

   assign redirect    = r_redirect;
   assign redirect_pc = r_redirect_pc;
   assign squash      = r_squash;
   assign link_wr     = r_link_wr;
   assign link_data   = r_link_data;
   assign misalign    = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_redirect_ctrl
// Description : Directed self-checking bench for branch_redirect_ctrl
//               (XLEN=32, FLUSH_DEPTH=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_redirect_ctrl;

   logic        clk;
   logic        rst;
   logic        en;
   logic        ex_valid, ex_is_jal, ex_is_jalr, ex_is_branch, ex_taken;
   logic [31:0] ex_pc, ex_imm, ex_rs1;
   logic        redirect, squash, link_wr, misalign;
   logic [31:0] redirect_pc, link_data;

   int n_checks = 0;
   int n_errors = 0;

   branch_redirect_ctrl #(.XLEN(32), .FLUSH_DEPTH(2)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .ex_valid     (ex_valid),
      .ex_is_jal    (ex_is_jal),
      .ex_is_jalr   (ex_is_jalr),
      .ex_is_branch (ex_is_branch),
      .ex_taken     (ex_taken),
      .ex_pc        (ex_pc),
      .ex_imm       (ex_imm),
      .ex_rs1       (ex_rs1),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .squash       (squash),
      .link_wr      (link_wr),
      .link_data    (link_data),
      .misalign     (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic red, input logic [31:0] rpc,
                            input logic sq, input logic lw, input logic [31:0] ld,
                            input logic mis);
      check_val({tag, ".redirect"},    {31'd0, redirect}, {31'd0, red});
      check_val({tag, ".redirect_pc"}, redirect_pc,       rpc);
      check_val({tag, ".squash"},      {31'd0, squash},   {31'd0, sq});
      check_val({tag, ".link_wr"},     {31'd0, link_wr},  {31'd0, lw});
      check_val({tag, ".link_data"},   link_data,         ld);
      check_val({tag, ".misalign"},    {31'd0, misalign}, {31'd0, mis});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ex(input logic jal, input logic jalr, input logic br, input logic tk,
                           input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1);
      ex_valid     = 1'b1;
      ex_is_jal    = jal;
      ex_is_jalr   = jalr;
      ex_is_branch = br;
      ex_taken     = tk;
      ex_pc        = pc;
      ex_imm       = imm;
      ex_rs1       = rs1;
   endtask

   task automatic clr_ex();
      ex_valid     = 1'b0;
      ex_is_jal    = 1'b0;
      ex_is_jalr   = 1'b0;
      ex_is_branch = 1'b0;
      ex_taken     = 1'b0;
      ex_pc        = 32'h0;
      ex_imm       = 32'h0;
      ex_rs1       = 32'h0;
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      clr_ex();
      step();
      step();
      rst = 1'b0;
      check_out("reset", 0, 32'h0, 0, 0, 32'h0, 0);

      // JAL 0x100 + 0x20
      drive_ex(1, 0, 0, 0, 32'h100, 32'h20, 32'h0);
      step();
      check_out("jal_t1", 1, 32'h120, 1, 1, 32'h104, 0);
      clr_ex();
      step();
      check_out("jal_t2", 0, 32'h120, 1, 0, 32'h104, 0);
      step();
      check_out("jal_t3", 0, 32'h120, 0, 0, 32'h104, 0);

      // JALR rs1=0x2001 imm=4 -> 0x2004
      drive_ex(0, 1, 0, 0, 32'h200, 32'h4, 32'h2001);
      step();
      check_out("jalr_t1", 1, 32'h2004, 1, 1, 32'h204, 0);
      clr_ex();
      step();
      check_out("jalr_t2", 0, 32'h2004, 1, 0, 32'h204, 0);
      step();
      check_out("jalr_t3", 0, 32'h2004, 0, 0, 32'h204, 0);

      // Taken branch, then 3 held cycles
      drive_ex(0, 0, 1, 1, 32'h300, 32'h40, 32'h0);
      step();
      check_out("br_t1", 1, 32'h340, 1, 0, 32'h304, 0);
      clr_ex();
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_out("br_hold", 1, 32'h340, 1, 0, 32'h304, 0);
      end
      en = 1'b0;
      step();
      check_out("br_sq", 0, 32'h340, 1, 0, 32'h304, 0);
      step();
      check_out("br_idle", 0, 32'h340, 0, 0, 32'h304, 0);

      // Misaligned JAL 0x100 + 6 -> 0x106
      drive_ex(1, 0, 0, 0, 32'h100, 32'h6, 32'h0);
      step();
      check_out("mis_t1", 0, 32'h340, 0, 0, 32'h304, 1);
      // Next event accepted immediately
      drive_ex(1, 0, 0, 0, 32'h400, 32'h10, 32'h0);
      step();
      check_out("after_mis", 1, 32'h410, 1, 1, 32'h404, 0);
      // Second jump presented in REDIRECT/SQUASH must be ignored
      drive_ex(1, 0, 0, 0, 32'h500, 32'h80, 32'h0);
      step();
      check_out("ign_sq", 0, 32'h410, 1, 0, 32'h404, 0);
      en = 1'b1;
      step();
      check_out("ign_sq_hold", 0, 32'h410, 1, 0, 32'h404, 0);
      en = 1'b0;
      step();
      check_out("ign_idle", 0, 32'h410, 0, 0, 32'h404, 0);
      clr_ex();

      // Event with en=1 is not sampled
      en = 1'b1;
      drive_ex(1, 0, 0, 0, 32'h700, 32'h10, 32'h0);
      step();
      check_out("en_hold_ev", 0, 32'h410, 0, 0, 32'h404, 0);
      en = 1'b0;
      step();
      check_out("en_rel_ev", 1, 32'h710, 1, 1, 32'h704, 0);
      clr_ex();
      step();
      step();
      check_out("en_rel_idle", 0, 32'h710, 0, 0, 32'h704, 0);

      // Wrap-around JAL
      drive_ex(1, 0, 0, 0, 32'hFFFF_FFFC, 32'h8, 32'h0);
      step();
      check_out("wrap_t1", 1, 32'h4, 1, 1, 32'h0, 0);
      // Repeat jump with reset during REDIRECT
      rst = 1'b1;
      step();
      check_out("rst_mid", 0, 32'h0, 0, 0, 32'h0, 0);
      rst = 1'b0;
      clr_ex();
      step();
      check_out("rst_idle", 0, 32'h0, 0, 0, 32'h0, 0);
      // State must be IDLE: a new jump is accepted at once
      drive_ex(1, 0, 0, 0, 32'h600, 32'h8, 32'h0);
      step();
      check_out("post_rst", 1, 32'h608, 1, 1, 32'h604, 0);
      clr_ex();
      step();
      step();
      check_out("final_idle", 0, 32'h608, 0, 0, 32'h604, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
